spectrum_peak_finder: RTL and testbench

SPECTRUM_PEAK_FINDER -- requirements
Module: spectrum_peak_finder

---
 rtl/spectrum_peak_finder.sv | 139 +++++++++++++
 tb/tb_spectrum_peak_finder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_finder.sv
// Spectrum peak finder: scans one FFT frame of IEEE-754 magnitude-squared bins
// and reports the largest eligible bin, its index and a frame-length error flag.
module spectrum_peak_finder #(
   parameter int N_BINS    = 128,
   parameter int IDX_W     = 7,
   parameter int SKIP_DC   = 1,
   parameter int HALF_ONLY = 1
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [31:0]      s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   input  logic             s_axis_tlast,
   output logic [31:0]      m_peak_mag,
   output logic [IDX_W-1:0] m_peak_idx,
   output logic             m_frame_err,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [1:0]       fsm_state
);

   // Handshakes: an input beat moves when s_axis_tvalid && s_axis_tready at a
   // rising edge; a result moves when m_valid && m_ready at a rising edge.
   // Once raised, m_valid and the result fields hold until that edge.

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   localparam logic [IDX_W:0] FRAME_LEN = (IDX_W+1)'(N_BINS);

   state_t           state;
   logic [IDX_W:0]   cnt;
   logic [31:0]      best;
   logic [IDX_W-1:0] best_idx;
   logic             have_best;
   logic             drop_pending;

   logic             xfer;
   logic [IDX_W-1:0] bin_idx;
   logic [IDX_W:0]   cnt_inc;
   logic             last_bin;
   logic             eligible;
   logic             is_nan;
   logic [31:0]      san;
   logic [31:0]      cand_best;
   logic [IDX_W-1:0] cand_idx;

   assign xfer      = s_axis_tvalid && s_axis_tready;
   assign bin_idx   = cnt[IDX_W-1:0];
   assign cnt_inc   = cnt + 1'b1;
   assign last_bin  = (cnt_inc == FRAME_LEN);
   assign eligible  = !((SKIP_DC != 0) && (bin_idx == '0)) &&
                      !((HALF_ONLY != 0) && bin_idx[IDX_W-1]);
   assign is_nan    = (&s_axis_tdata[30:23]) && (|s_axis_tdata[22:0]);
   assign san       = s_axis_tdata[31] ? 32'h0000_0000 : s_axis_tdata;
   assign fsm_state = state;

   // Non-negative IEEE singles order the same as their raw bit patterns, so a
   // plain unsigned compare finds the maximum; strict '>' keeps the lowest index.
   always_comb begin
      cand_best = best;
      cand_idx  = best_idx;
      if (eligible) begin
         if (!have_best) begin
            cand_best = is_nan ? 32'h0000_0000 : san;
            cand_idx  = bin_idx;
         end else if (!is_nan && (san > best)) begin
            cand_best = san;
            cand_idx  = bin_idx;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= ACCUM;
         cnt           <= '0;
         best          <= '0;
         best_idx      <= '0;
         have_best     <= 1'b0;
         drop_pending  <= 1'b0;
         m_valid       <= 1'b0;
         m_peak_mag    <= '0;
         m_peak_idx    <= '0;
         m_frame_err   <= 1'b0;
         s_axis_tready <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               s_axis_tready <= 1'b1;
               if (xfer) begin
                  cnt       <= cnt_inc;
                  best      <= cand_best;
                  best_idx  <= cand_idx;
                  have_best <= have_best || eligible;
                  // A frame ends on tlast or on a full frame without tlast;
                  // the latter leaves the tail of that frame to be dropped.
                  if (s_axis_tlast || last_bin) begin
                     m_peak_mag    <= cand_best;
                     m_peak_idx    <= cand_idx;
                     m_frame_err   <= !(s_axis_tlast && last_bin);
                     drop_pending  <= !s_axis_tlast;
                     m_valid       <= 1'b1;
                     s_axis_tready <= 1'b0;
                     state         <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (m_ready) begin
                  m_valid       <= 1'b0;
                  cnt           <= '0;
                  best          <= '0;
                  best_idx      <= '0;
                  have_best     <= 1'b0;
                  s_axis_tready <= 1'b1;
                  state         <= drop_pending ? DROP : ACCUM;
               end
            end
            DROP: begin
               s_axis_tready <= 1'b1;
               if (xfer && s_axis_tlast) begin
                  drop_pending <= 1'b0;
                  state        <= ACCUM;
               end
            end
            default: begin
               s_axis_tready <= 1'b0;
               state         <= ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed bench for spectrum_peak_finder: expected results are queued by the
// stimulus and a negedge monitor compares them at each result handshake.
module tb_spectrum_peak_finder;

   localparam int N_BINS = 128;
   localparam int IDX_W  = 7;
   localparam int W      = 32 + IDX_W + 1;
   localparam int BUDGET = 400;

   logic             aclk = 1'b0;
   logic             areset;
   logic [31:0]      s_axis_tdata;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic             s_axis_tlast;
   logic [31:0]      m_peak_mag;
   logic [IDX_W-1:0] m_peak_idx;
   logic             m_frame_err;
   logic             m_valid;
   logic             m_ready;
   logic [1:0]       fsm_state;

   logic [W-1:0] exp_q[$];
   logic [31:0]  fd[0:255];
   int           n_checks = 0;
   int           n_pass   = 0;

   spectrum_peak_finder #(
      .N_BINS(N_BINS), .IDX_W(IDX_W), .SKIP_DC(1), .HALF_ONLY(1)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_peak_mag(m_peak_mag), .m_peak_idx(m_peak_idx),
      .m_frame_err(m_frame_err), .m_valid(m_valid), .m_ready(m_ready),
      .fsm_state(fsm_state)
   );

   // clock / watchdog
   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   function automatic logic [W-1:0] make_exp(input logic [31:0] mag,
                                             input logic [IDX_W-1:0] idx,
                                             input logic err);
      return {mag, idx, err};
   endfunction

   // scoreboard monitor: one pop per result handshake
   always begin
      logic [W-1:0] e;
      @(negedge aclk);
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(m_peak_idx), 64'hFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("peak_mag", 64'(m_peak_mag), 64'(e[W-1 -: 32]));
            chk("peak_idx", 64'(m_peak_idx), 64'(e[IDX_W:1]));
            chk("frame_err", 64'(m_frame_err), 64'(e[0]));
         end
      end
   end

   // driver tasks
   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < 256; i++) fd[i] = v;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last, input int gap);
      int cyc;
      s_axis_tvalid = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge aclk);
         #1;
      end
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      cyc = 0;
      @(negedge aclk);
      while (!s_axis_tready && cyc < BUDGET) begin
         @(negedge aclk);
         cyc++;
      end
      chk("tready_wait", 64'(s_axis_tready), 64'd1);
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int len, input int gap_mode);
      for (int i = 0; i < len; i++)
         send_beat(fd[i], (i == len - 1), (gap_mode != 0) ? (i % 3) : 0);
   endtask

   task automatic wait_drain();
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < BUDGET) begin
         @(posedge aclk);
         cyc++;
      end
      #1;
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_ready       = 1'b1;

      // reset state
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_mag", 64'(m_peak_mag), 64'd0);
      chk("rst_idx", 64'(m_peak_idx), 64'd0);
      chk("rst_err", 64'(m_frame_err), 64'd0);
      chk("rst_state", 64'(fsm_state), 64'd0);
      areset = 1'b0;
      #1;
      chk("tready_before_edge", 64'(s_axis_tready), 64'd0);
      @(posedge aclk);
      #1;
      chk("tready_after_edge", 64'(s_axis_tready), 64'd1);

      // single peak among ones, plus 1-cycle result latency
      fill(32'h3F80_0000);
      fd[5] = 32'h40A0_0000;
      exp_q.push_back(make_exp(32'h40A0_0000, 7'd5, 1'b0));
      send_frame(128, 0);
      chk("latency_valid", 64'(m_valid), 64'd1);
      wait_drain();

      // DC, upper half and tie exclusion
      fill(32'h0);
      fd[0]  = 32'h42C8_0000;
      fd[70] = 32'h42C8_0000;
      fd[3]  = 32'h4120_0000;
      fd[9]  = 32'h4120_0000;
      exp_q.push_back(make_exp(32'h4120_0000, 7'd3, 1'b0));
      send_frame(128, 0);
      wait_drain();

      // short frame with tvalid gaps
      fill(32'h0);
      fd[10] = 32'h4000_0000;
      exp_q.push_back(make_exp(32'h4000_0000, 7'd10, 1'b1));
      send_frame(100, 1);
      wait_drain();

      // one-beat frame: no eligible bins
      fill(32'h0);
      fd[0] = 32'h4200_0000;
      exp_q.push_back(make_exp(32'h0, 7'd0, 1'b1));
      send_frame(1, 0);
      wait_drain();

      // overlong frame: tail dropped, next frame clean
      fill(32'h0);
      fd[20] = 32'h4040_0000;
      for (int i = 128; i < 140; i++) fd[i] = 32'h7F00_0000;
      exp_q.push_back(make_exp(32'h4040_0000, 7'd20, 1'b1));
      send_frame(140, 0);
      wait_drain();
      chk("state_after_drop", 64'(fsm_state), 64'd0);
      fill(32'h0);
      fd[7] = 32'h3F80_0000;
      exp_q.push_back(make_exp(32'h3F80_0000, 7'd7, 1'b0));
      send_frame(128, 0);
      wait_drain();

      // back-pressure on the result
      m_ready = 1'b0;
      fill(32'h0);
      fd[2] = 32'h4100_0000;
      exp_q.push_back(make_exp(32'h4100_0000, 7'd2, 1'b0));
      send_frame(128, 0);
      chk("bp_valid_rise", 64'(m_valid), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         chk("bp_tready", 64'(s_axis_tready), 64'd0);
         chk("bp_valid", 64'(m_valid), 64'd1);
         chk("bp_mag", 64'(m_peak_mag), 64'h4100_0000);
         chk("bp_idx", 64'(m_peak_idx), 64'd2);
         chk("bp_err", 64'(m_frame_err), 64'd0);
      end
      @(posedge aclk);
      #1;
      m_ready = 1'b1;
      @(posedge aclk);
      #1;
      chk("post_hs_tready", 64'(s_axis_tready), 64'd1);
      chk("post_hs_valid", 64'(m_valid), 64'd0);
      wait_drain();

      // NaN ignored, negative treated as zero, with gaps
      fill(32'h0);
      fd[4] = 32'h7FC0_0000;
      fd[6] = 32'hBF80_0000;
      fd[8] = 32'h3F00_0000;
      exp_q.push_back(make_exp(32'h3F00_0000, 7'd8, 1'b0));
      send_frame(128, 1);
      wait_drain();

      // reset mid-frame abandons the partial frame
      fill(32'h0);
      fd[40] = 32'h7F7F_FFFF;
      for (int i = 0; i < 50; i++) send_beat(fd[i], 1'b0, 0);
      areset = 1'b1;
      #3;
      chk("midrst_tready", 64'(s_axis_tready), 64'd0);
      chk("midrst_state", 64'(fsm_state), 64'd0);
      chk("midrst_valid", 64'(m_valid), 64'd0);
      @(negedge aclk);
      areset = 1'b0;
      fill(32'h0);
      fd[9] = 32'h4080_0000;
      exp_q.push_back(make_exp(32'h4080_0000, 7'd9, 1'b0));
      send_frame(128, 0);
      wait_drain();

      repeat (20) @(posedge aclk);
      #1;
      chk("final_queue", 64'(exp_q.size()), 64'd0);
      chk("final_valid", 64'(m_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
